init: RTL and testbench
=======================

Name: init

Overview:
- Key-schedule initialisation engine for the ARC4 decryption datapath.
- On request, fills the external 256-entry S memory with the identity permutation, S[i] = i for i = 0..255.
- Uses the codebase's en/rdy request handshake.
- Sits between the top-level ARC4 controller (drives en, watches rdy) and the S-memory write port (addr/wrdata/wren).

Parameters:
- ADDR_W, 8, width of addr and wrdata; the fill covers 2**ADDR_W entries.
- Only the default value is required to be supported and verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  start request; sampled only on a rising edge where rdy=1.
- rdy  output  1  high = idle and able to accept a request.
- addr  output  8  S-memory write address.
- wrdata  output  8  S-memory write data; always equals addr while writing.
- wren  output  1  S-memory write enable, active high.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n, with clock named clk.
- Reset (rst_n=0), asynchronous and dominant over everything:
  - rdy=1, wren=0, addr=8'h00, wrdata=8'h00.
  - FSM goes to IDLE.
  - Applies immediately, including mid-fill; the aborted fill is not resumed.
- Release of rst_n has no side effect; the block waits in IDLE.
- FSM states:
  - IDLE: rdy=1, wren=0, addr and wrdata held at their last value (00 after reset). On a rising edge with en=1, go to FILL with counter=0.
  - FILL: rdy=0, wren=1, addr=counter, wrdata=counter. Each edge increments counter. On the edge where counter=255, go to DONE.
  - DONE: one cycle with rdy=0, wren=0, then return to IDLE. This guarantees wren is low before rdy rises.
- Latency:
  - en sampled at edge E.
  - Writes to addresses 0x00..0xFF occur in the 256 cycles after E, one entry per cycle in ascending order, no gaps.
  - rdy is low for exactly 257 cycles and returns high after the edge E+257.
- en while busy (FILL/DONE) is ignored; it is not queued.
- en held high continuously: after returning to IDLE, rdy is high and a new fill starts at the next edge. rdy is therefore visible high for at least one full cycle between fills.
- en low in IDLE: no activity, outputs stable.
- Counter wraps are never used: the FILL exit happens at 255 before increment overflow.
- All outputs are registered; no combinational path from en to any output.
- addr and wrdata are never driven X after reset.

Decomposition:
- Shared package arc4_pkg holds:
  - ADDR_W default 8 and S_SIZE = 256.
  - FSM state typedef enum {IDLE, FILL, DONE}, reused by the sibling ksa/prga controllers for handshake consistency.
- No sub-module is needed. The counter and FSM are kept inline in a single module.

Test Plan:
- Reset with en=1: hold rst_n=0 for one cycle, check rdy=1, wren=0, addr=00, wrdata=00. Release rst_n with en=1, then check at the next edge: rdy=0, wren=1, addr=00, wrdata=00.
- Full fill:
  - Start with a single-cycle en pulse.
  - Record every cycle with wren=1: exactly 256 writes, addr 00..FF ascending, wrdata==addr each cycle.
  - Check rdy=0 throughout, then rdy=1 and wren=0 after 257 cycles.
- Idle with en=0 after reset release: run 20 cycles, check rdy=1 and wren=0 and addr constant at 00.
- Reset mid-operation:
  - Start a fill and wait about 10 cycles (addr near 09).
  - Assert rst_n=0 between edges: outputs return to rdy=1, wren=0, addr=00 without waiting for a clock.
  - Set en=0, release rst_n: block stays idle.
- Busy-ignore: pulse en again at addr=40 during FILL. The sequence continues unchanged to FF, and only one fill occurs (rdy stays high after completion when en is low).
- Back-to-back: hold en=1 for more than 600 cycles. Two complete fills occur, separated by a DONE cycle and exactly one rdy=1 cycle. The second fill restarts at addr=00.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 datapath definitions: S-memory geometry and the en/rdy
// controller state encoding used by init, ksa and prga.
package arc4_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned S_SIZE = 256;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/init.sv
// ARC4 S-memory initialisation: on request writes S[i] = i for every entry,
// one entry per cycle, then drops wren for a cycle before raising rdy.
module init
    import arc4_pkg::*;
#(
    parameter int unsigned ADDR_W = arc4_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] wrdata,
    output logic              wren
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_next;
    logic              wren_next;
    logic              rdy_next;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        wren_next  = wren;
        rdy_next   = rdy;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = FILL;
                    addr_next  = '0;
                    wren_next  = 1'b1;
                    rdy_next   = 1'b0;
                end
            end
            FILL: begin
                if (addr == '1) begin
                    state_next = DONE;
                    wren_next  = 1'b0;
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                rdy_next   = 1'b1;
            end
            default: begin
                state_next = IDLE;
                wren_next  = 1'b0;
                rdy_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            wren  <= 1'b0;
            rdy   <= 1'b1;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            wren  <= wren_next;
            rdy   <= rdy_next;
        end
    end

    // The write counter doubles as the data value, so wrdata tracks addr exactly.
    assign wrdata = addr;

endmodule

// File: tb/tb_init.sv
// Directed self-checking bench for the ARC4 S-memory initialisation engine.
module tb_init;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;

    int n_checks;
    int n_fail;

    init #(.ADDR_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en    = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_cycle(input string name, input int j,
                               input logic exp_rdy, input logic exp_wren,
                               input logic [7:0] exp_addr);
        n_checks++;
        if (rdy !== exp_rdy || wren !== exp_wren || addr !== exp_addr || wrdata !== exp_addr) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cycle %0d: got rdy=%b wren=%b addr=%h wrdata=%h, expected rdy=%b wren=%b addr=%h wrdata=%h",
                         name, j, rdy, wren, addr, wrdata, exp_rdy, exp_wren, exp_addr, exp_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        tick();
        n_checks++;
        if (rdy !== 1'b1 || wren !== 1'b0 || addr !== 8'h00 || wrdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b wren=%b addr=%h wrdata=%h, expected 1 0 00 00",
                     rdy, wren, addr, wrdata);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (rdy !== 1'b0 || wren !== 1'b1 || addr !== 8'h00 || wrdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release_en: got rdy=%b wren=%b addr=%h wrdata=%h, expected 0 1 00 00",
                     rdy, wren, addr, wrdata);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            check_cycle("idle", i, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_full_fill();
        int writes;
        int exp_a;
        apply_reset();
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        writes = 0;
        exp_a  = 0;
        for (int j = 0; j <= 260; j++) begin
            if (wren === 1'b1) begin
                n_checks++;
                if (addr !== 8'(exp_a) || wrdata !== 8'(exp_a) || rdy !== 1'b0) begin
                    n_fail++;
                    if (n_fail <= 30)
                        $display("FAIL fill_write %0d: got addr=%h wrdata=%h rdy=%b, expected addr=%h wrdata=%h rdy=0",
                                 writes, addr, wrdata, rdy, 8'(exp_a), 8'(exp_a));
                end
                writes++;
                exp_a++;
            end
            if (j == 256) check_cycle("fill_done", j, 1'b0, 1'b0, 8'hFF);
            if (j == 257) check_cycle("fill_ready", j, 1'b1, 1'b0, 8'hFF);
            if (j < 256 && rdy !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fill_rdy cycle %0d: got rdy=%b, expected 0", j, rdy);
            end
            tick();
        end
        n_checks++;
        if (writes != 256) begin
            n_fail++;
            $display("FAIL fill_count: got %0d writes, expected 256", writes);
        end
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_cycle("mid_fill_pre", 9, 1'b0, 1'b1, 8'h09);
        #2;
        rst_n = 1'b0;
        #1;
        check_cycle("mid_fill_async_reset", 0, 1'b1, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_cycle("post_reset_idle", i, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic test_busy_ignore();
        int guard;
        apply_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        guard = 0;
        while (addr !== 8'h40 && guard < 300) begin
            tick();
            guard++;
        end
        n_checks++;
        if (addr !== 8'h40) begin
            n_fail++;
            $display("FAIL busy_reach_40: got addr=%h after %0d cycles, expected 40", addr, guard);
        end else begin
            en = 1'b1;
            tick();
            en = 1'b0;
            for (int j = 8'h41; j <= 8'hFF; j++) begin
                check_cycle("busy_seq", j, 1'b0, 1'b1, 8'(j));
                tick();
            end
            check_cycle("busy_done", 256, 1'b0, 1'b0, 8'hFF);
            for (int i = 0; i < 10; i++) begin
                tick();
                check_cycle("busy_single_fill", i, 1'b1, 1'b0, 8'hFF);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p;
        apply_reset();
        en = 1'b1;
        tick();
        for (int j = 0; j < 620; j++) begin
            p = j % 258;
            if (p <= 255)      check_cycle("b2b", j, 1'b0, 1'b1, 8'(p));
            else if (p == 256) check_cycle("b2b", j, 1'b0, 1'b0, 8'hFF);
            else               check_cycle("b2b", j, 1'b1, 1'b0, 8'hFF);
            tick();
        end
        en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        test_reset();
        test_idle();
        test_full_fill();
        test_reset_mid_fill();
        test_busy_ignore();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
